// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-Lite slave port between the instruction fetch
// unit (read-only) and the load/store unit (read + write). One transaction at
// a time, LSU preferred, with a bounded-wait counter so a pending IFU fetch is
// never starved for more than MAX_WAIT consecutive LSU grants.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read channels
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Slave port
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  output logic                m_rready,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_awready,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  // Debug: current owner of the slave port
  output logic [1:0]          grant
);

  // MAX_WAIT=0 still needs a 1-bit counter; it simply never leaves zero.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFU_RD = 2'd1;
  localparam logic [1:0] LSU_RD = 2'd2;
  localparam logic [1:0] LSU_WR = 2'd3;

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] starveCnt;
  logic             wrReq, rdReq, ifReq;

  assign wrReq = lsu_awvalid | lsu_wvalid;
  assign rdReq = lsu_arvalid;
  assign ifReq = ifu_arvalid;
  assign grant = state;

  // Arbitrate from IDLE; release the grant on the final response handshake.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (ifReq && (starveCnt == WAIT_MAX)) stateNext = IFU_RD;
        else if (wrReq)                       stateNext = LSU_WR;
        else if (rdReq)                       stateNext = LSU_RD;
        else if (ifReq)                       stateNext = IFU_RD;
      end
      IFU_RD: if (m_rvalid && ifu_rready) stateNext = IDLE;
      LSU_RD: if (m_rvalid && lsu_rready) stateNext = IDLE;
      LSU_WR: if (m_bvalid && lsu_bready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register and IFU starvation counter (counts LSU wins over a waiting IFU).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        if (stateNext == IFU_RD)
          starveCnt <= '0;
        else if ((stateNext == LSU_RD || stateNext == LSU_WR) && ifReq &&
                 (starveCnt != WAIT_MAX))
          starveCnt <= starveCnt + 1'b1;
      end
    end
  end

  // Route the owner's channels to the slave; everything else is held at zero.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    case (state)
      IFU_RD: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid;
        m_rready    = ifu_rready;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
      end
      LSU_RD: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid;
        m_rready    = lsu_rready;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
      end
      LSU_WR: begin
        // AW and W pass through independently; the slave may take them in any order.
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid;
        m_bready    = lsu_bready;
        lsu_awready = m_awready;
        lsu_wready  = m_wready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
      end
      default: ;
    endcase
  end

endmodule
